// File: rtl/associado_pkg.sv
// rtl/associado_pkg.sv - profile codes, frame FSM states and parity helper for associado_tx
package associado_pkg;

    localparam logic [2:0] PROF_ADMIN  = 3'b101;
    localparam logic [2:0] PROF_TESTER = 3'b110;
    localparam logic [2:0] PROF_USER   = 3'b100;
    localparam logic [2:0] PROF_GUEST  = 3'b011;

    localparam int FRAME_BITS = 6;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Parity bit that makes {A,B,C,P} carry an even number of ones.
    function automatic logic even_parity(input logic [2:0] abc);
        return ^abc;
    endfunction

endpackage

// File: rtl/associado_enc.sv
// rtl/associado_enc.sv - maps a profile code to its associate bits {A,B,C}
module associado_enc
    import associado_pkg::*;
(
    input  logic [2:0] profile_in,
    output logic [2:0] abc,
    output logic       code_valid
);

    always_comb begin
        abc        = 3'b000;
        code_valid = 1'b0;
        case (profile_in)
            PROF_ADMIN: begin
                abc        = 3'b101;
                code_valid = 1'b1;
            end
            PROF_TESTER: begin
                abc        = 3'b011;
                code_valid = 1'b1;
            end
            PROF_USER: begin
                abc        = 3'b001;
                code_valid = 1'b1;
            end
            PROF_GUEST: begin
                abc        = 3'b110;
                code_valid = 1'b1;
            end
            default: begin
                abc        = 3'b000;
                code_valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/associado_tx.sv
// rtl/associado_tx.sv - serialises associate bits as start/A/B/C/parity/stop frame
module associado_tx
    import associado_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] profile_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       tx_line,
    output logic       busy,
    output logic       err_invalid,
    output logic       tx_done
);

    localparam logic [7:0] LAST_CNT = 8'(CLKS_PER_BIT - 1);

    state_t     state_q, state_n;
    logic [7:0] cnt_q, cnt_n;
    logic [1:0] bit_q, bit_n;
    logic [2:0] data_q, data_n;
    logic       par_q, par_n;
    logic       tx_n, done_n, err_n;
    logic [2:0] enc_abc;
    logic       enc_valid;
    logic       accept;
    logic       bit_end;

    associado_enc u_enc (
        .profile_in (profile_in),
        .abc        (enc_abc),
        .code_valid (enc_valid)
    );

    assign accept  = valid_in & ready_out;
    assign bit_end = (cnt_q == LAST_CNT);

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        bit_n   = bit_q;
        data_n  = data_q;
        par_n   = par_q;
        done_n  = 1'b0;
        err_n   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_n = 8'd0;
                bit_n = 2'd0;
                if (accept) begin
                    if (enc_valid) begin
                        data_n  = enc_abc;
                        par_n   = even_parity(enc_abc);
                        state_n = ST_START;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            ST_START: begin
                cnt_n = bit_end ? 8'd0 : cnt_q + 8'd1;
                if (bit_end) state_n = ST_DATA;
            end
            ST_DATA: begin
                cnt_n = bit_end ? 8'd0 : cnt_q + 8'd1;
                if (bit_end) begin
                    if (bit_q == 2'd2) begin
                        bit_n   = 2'd0;
                        state_n = ST_PARITY;
                    end else begin
                        bit_n = bit_q + 2'd1;
                    end
                end
            end
            ST_PARITY: begin
                cnt_n = bit_end ? 8'd0 : cnt_q + 8'd1;
                if (bit_end) state_n = ST_STOP;
            end
            ST_STOP: begin
                cnt_n = bit_end ? 8'd0 : cnt_q + 8'd1;
                if (bit_end) begin
                    state_n = ST_IDLE;
                    done_n  = 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = 8'd0;
                bit_n   = 2'd0;
            end
        endcase

        // Line level is decoded from the next state so tx_line stays a plain flop.
        tx_n = 1'b1;
        case (state_n)
            ST_START: tx_n = 1'b0;
            ST_DATA: begin
                case (bit_n)
                    2'd0:    tx_n = data_n[2];
                    2'd1:    tx_n = data_n[1];
                    default: tx_n = data_n[0];
                endcase
            end
            ST_PARITY: tx_n = par_n;
            default:   tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 8'd0;
            bit_q       <= 2'd0;
            data_q      <= 3'b000;
            par_q       <= 1'b0;
            tx_line     <= 1'b1;
            ready_out   <= 1'b1;
            busy        <= 1'b0;
            err_invalid <= 1'b0;
            tx_done     <= 1'b0;
        end else begin
            state_q     <= state_n;
            cnt_q       <= cnt_n;
            bit_q       <= bit_n;
            data_q      <= data_n;
            par_q       <= par_n;
            tx_line     <= tx_n;
            ready_out   <= (state_n == ST_IDLE);
            busy        <= (state_n != ST_IDLE);
            err_invalid <= err_n;
            tx_done     <= done_n;
        end
    end

endmodule

// File: tb/tb_associado_tx.sv
// tb/tb_associado_tx.sv - randomized self-checking bench for associado_tx
module tb_associado_tx;
    import associado_pkg::*;

    logic       clk = 1'b0;
    logic       reset       [2];
    logic [2:0] profile_in  [2];
    logic       valid_in    [2];
    logic       ready_out   [2];
    logic       tx_line     [2];
    logic       busy        [2];
    logic       err_invalid [2];
    logic       tx_done     [2];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    associado_tx #(.CLKS_PER_BIT(4)) u_tx4 (
        .clk         (clk),
        .reset       (reset[0]),
        .profile_in  (profile_in[0]),
        .valid_in    (valid_in[0]),
        .ready_out   (ready_out[0]),
        .tx_line     (tx_line[0]),
        .busy        (busy[0]),
        .err_invalid (err_invalid[0]),
        .tx_done     (tx_done[0])
    );

    associado_tx #(.CLKS_PER_BIT(1)) u_tx1 (
        .clk         (clk),
        .reset       (reset[1]),
        .profile_in  (profile_in[1]),
        .valid_in    (valid_in[1]),
        .ready_out   (ready_out[1]),
        .tx_line     (tx_line[1]),
        .busy        (busy[1]),
        .err_invalid (err_invalid[1]),
        .tx_done     (tx_done[1])
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference profile table: {valid, A, B, C}.
    function automatic logic [3:0] ref_map(input logic [2:0] code);
        case (code)
            3'b101:  return 4'b1101;
            3'b110:  return 4'b1011;
            3'b100:  return 4'b1001;
            3'b011:  return 4'b1110;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic int ref_unmap(input logic [2:0] abc);
        for (int c = 0; c < 8; c++) begin
            logic [3:0] m;
            m = ref_map(3'(c));
            if (m[3] && m[2:0] == abc) return c;
        end
        return -1;
    endfunction

    function automatic int ref_bit(input logic [2:0] code, input int pos);
        logic [3:0] m;
        m = ref_map(code);
        case (pos)
            0:       return 0;
            1:       return int'(m[2]);
            2:       return int'(m[1]);
            3:       return int'(m[0]);
            4:       return int'(m[2] ^ m[1] ^ m[0]);
            default: return 1;
        endcase
    endfunction

    function automatic int clks(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    task automatic send(input int i, input logic [2:0] code);
        int n;
        logic [2:0] got_abc;
        logic got_par;
        n = clks(i);
        got_abc = 3'b000;
        got_par = 1'b0;
        profile_in[i] = code;
        valid_in[i] = 1'b1;
        check("ready_before_accept", int'(ready_out[i]), 1);
        @(negedge clk);
        check("ready_after_accept", int'(ready_out[i]), 0);
        for (int k = 0; k < FRAME_BITS * n; k++) begin
            int pos;
            pos = k / n;
            check("tx_bit", int'(tx_line[i]), ref_bit(code, pos));
            check("busy_in_frame", int'(busy[i]), 1);
            if (k % n == n / 2) begin
                if (pos >= 1 && pos <= 3) got_abc[3 - pos] = tx_line[i];
                if (pos == 4) got_par = tx_line[i];
            end
            profile_in[i] = 3'($urandom);
            valid_in[i] = 1'($urandom);
            @(negedge clk);
        end
        valid_in[i] = 1'b0;
        check("rx_decode", ref_unmap(got_abc), int'(code));
        check("rx_even_parity", int'(got_par ^ (^got_abc)), 0);
        check("tx_done_pulse", int'(tx_done[i]), 1);
        check("done_ready", int'(ready_out[i]), 1);
        check("done_busy", int'(busy[i]), 0);
        check("done_line", int'(tx_line[i]), 1);
    endtask

    task automatic idle_check(input int i);
        @(negedge clk);
        check("idle_done", int'(tx_done[i]), 0);
        check("idle_err", int'(err_invalid[i]), 0);
        check("idle_line", int'(tx_line[i]), 1);
        check("idle_ready", int'(ready_out[i]), 1);
    endtask

    task automatic send_invalid(input int i, input logic [2:0] code);
        profile_in[i] = code;
        valid_in[i] = 1'b1;
        check("inv_ready_before", int'(ready_out[i]), 1);
        @(negedge clk);
        valid_in[i] = 1'b0;
        check("inv_err_pulse", int'(err_invalid[i]), 1);
        check("inv_line", int'(tx_line[i]), 1);
        check("inv_busy", int'(busy[i]), 0);
        check("inv_ready", int'(ready_out[i]), 1);
        @(negedge clk);
        check("inv_err_cleared", int'(err_invalid[i]), 0);
        check("inv_line_after", int'(tx_line[i]), 1);
        check("inv_busy_after", int'(busy[i]), 0);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            reset[i] = 1'b1;
            valid_in[i] = 1'b0;
            profile_in[i] = 3'b000;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_line", int'(tx_line[i]), 1);
            check("rst_ready", int'(ready_out[i]), 1);
            check("rst_busy", int'(busy[i]), 0);
            check("rst_err", int'(err_invalid[i]), 0);
            check("rst_done", int'(tx_done[i]), 0);
            reset[i] = 1'b0;
        end

        send(0, 3'b101); idle_check(0);
        send(0, 3'b100); idle_check(0);
        send(0, 3'b011); idle_check(0);
        send(0, 3'b110); idle_check(0);

        send_invalid(0, 3'b000);
        send_invalid(0, 3'b001);
        send_invalid(0, 3'b010);
        send_invalid(0, 3'b111);

        // Back-to-back: the second accept lands in the tx_done cycle.
        send(0, 3'b011);
        send(0, 3'b110);
        idle_check(0);

        // Reset during data bit B of an ADMIN frame.
        profile_in[0] = 3'b101;
        valid_in[0] = 1'b1;
        @(negedge clk);
        valid_in[0] = 1'b0;
        repeat (9) @(negedge clk);
        check("pre_reset_bit_b", int'(tx_line[0]), 0);
        check("pre_reset_busy", int'(busy[0]), 1);
        reset[0] = 1'b1;
        @(negedge clk);
        reset[0] = 1'b0;
        check("mid_rst_line", int'(tx_line[0]), 1);
        check("mid_rst_busy", int'(busy[0]), 0);
        check("mid_rst_ready", int'(ready_out[0]), 1);
        check("mid_rst_done", int'(tx_done[0]), 0);
        check("mid_rst_err", int'(err_invalid[0]), 0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("post_rst_no_done", int'(tx_done[0]), 0);
            check("post_rst_line", int'(tx_line[0]), 1);
        end
        send(0, 3'b100); idle_check(0);

        send(1, 3'b100); idle_check(1);

        for (int r = 0; r < 16; r++) begin
            int i;
            logic [2:0] code;
            logic [3:0] m;
            i = int'($urandom_range(1, 0));
            code = 3'($urandom_range(7, 0));
            m = ref_map(code);
            if (m[3]) send(i, code);
            else send_invalid(i, code);
            idle_check(i);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
